// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus-level bit constants shared by the I2C target and master.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_MACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    // General call (address 0) is never claimed, whatever the device address.
    function automatic logic addr_match(input logic [7:0] b, input logic [6:0] dev);
        return (b[7:1] == dev) && (b[7:1] != 7'h00);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronizes SCL/SDA and derives SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic res_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;

    // Flops reset to the idle bus level so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_o;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: oversampling I2C target giving a host access to an 8-bit register space
// through single-cycle write/read strobes; open-drain SDA, no clock stretching.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h3e,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       i2c_clk,
    inout  wire        i2c_sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       addressed
);

    logic       sda_s, scl_rise, scl_fall, start, stop;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic       ld_q, ld_d;
    logic       busy_q, busy_d;
    logic       addressed_q, addressed_d;
    logic [7:0] rx_byte;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .res_n      (res_n),
        .scl_i      (i2c_clk),
        .sda_i      (i2c_sda),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    assign rx_byte = {sr_q[6:0], sda_s};

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= 1'b0;
            oe_q        <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            ld_q        <= 1'b0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            oe_q        <= oe_d;
            we_q        <= we_d;
            re_q        <= re_d;
            ld_q        <= ld_d;
            busy_q      <= busy_d;
            addressed_q <= addressed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        oe_d        = oe_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        ld_d        = re_q;
        busy_d      = busy_q;
        addressed_d = addressed_q;
        if (we_q) addr_d = addr_q + 8'd1;
        // Read data arrives one clk after the strobe; SCL is far slower, so no edge collides.
        if (ld_q) sr_d = reg_rdata;
        if (stop) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            oe_d        = 1'b0;
        end else if (start) begin
            state_d     = ST_DEV_ADDR;
            cnt_d       = '0;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            oe_d        = 1'b0;
        end else begin
            case (state_q)
                ST_DEV_ADDR, ST_REG_ADDR, ST_WDATA: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (state_q == ST_DEV_ADDR) begin
                                if (addr_match(rx_byte, DEV_ADDR)) begin
                                    addressed_d = 1'b1;
                                    rw_d        = rx_byte[0];
                                    re_d        = rx_byte[0] == I2C_READ;
                                    state_d     = ST_DEV_ACK;
                                end else begin
                                    state_d = ST_WAIT_STOP;
                                end
                            end else if (state_q == ST_REG_ADDR) begin
                                addr_d  = rx_byte;
                                state_d = ST_REG_ACK;
                            end else begin
                                wdata_d = rx_byte;
                                we_d    = 1'b1;
                                state_d = ST_WDATA_ACK;
                            end
                        end
                    end
                end
                ST_DEV_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    // First fall starts the ACK low, second fall ends it.
                    if (scl_fall) begin
                        oe_d = !oe_q;
                        if (oe_q) begin
                            cnt_d   = '0;
                            state_d = state_q != ST_DEV_ACK ? ST_WDATA :
                                      rw_q == I2C_WRITE ? ST_REG_ADDR : ST_RDATA;
                            if (state_q == ST_DEV_ACK && rw_q == I2C_READ) begin
                                cnt_d = 4'd1;
                                oe_d  = !sr_q[7];
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    // cnt counts bits already put on the bus; bit 7 leaves at cnt 0.
                    if (scl_fall) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = ST_MACK;
                        end else if (cnt_q == 4'd0) begin
                            oe_d = !sr_q[7];
                        end else begin
                            oe_d = !sr_q[6];
                            sr_d = sr_q << 1;
                        end
                    end
                end
                ST_MACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            addr_d  = addr_q + 8'd1;
                            re_d    = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_RDATA;
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                default: oe_d = 1'b0;
            endcase
        end
    end

    assign i2c_sda   = oe_q ? 1'b0 : 1'bz;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign busy      = busy_q;
    assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed I2C host sequences against i2c_target_regs with a register-file model.
module tb_i2c_target_regs;

    localparam int Q = 62;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       scl = 1'b1;
    logic       host_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata = 8'h00;
    logic       reg_we, reg_re, busy, addressed;

    int         checks = 0;
    int         errors = 0;
    int         we_n = 0;
    int         re_n = 0;
    int         both_n = 0;
    logic [7:0] we_addr [16];
    logic [7:0] we_data [16];
    logic [7:0] mem [256];

    assign sda = host_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #20 clk = ~clk;

    i2c_target_regs #(.DEV_ADDR(7'h3e), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .i2c_clk   (scl),
        .i2c_sda   (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .addressed (addressed)
    );

    always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

    always @(negedge clk) begin
        if (reg_we && we_n < 16) begin
            we_addr[we_n] = reg_addr;
            we_data[we_n] = reg_wdata;
        end
        if (reg_we) we_n++;
        if (reg_re) re_n++;
        if (reg_we && reg_re) both_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        host_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        s = sda;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        host_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        host_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        host_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        host_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(mack, s);
    endtask

    initial begin
        logic       a0, a1, a2, a3, s;
        logic [7:0] d0, d1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h33;
        mem[8'h21] = 8'h44;
        mem[8'h40] = 8'h0f;

        wait_clk(5);
        chk("rst_busy", busy, 0);
        chk("rst_addressed", addressed, 0);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_we", reg_we, 0);
        chk("rst_re", reg_re, 0);
        chk("rst_sda", sda, 1);
        res_n = 1'b1;
        wait_clk(10);

        // Burst write of two bytes starting at 0x10
        i2c_start();
        write_byte(8'h7c, a0);
        chk("wr_addressed", addressed, 1);
        chk("wr_busy", busy, 1);
        write_byte(8'h10, a1);
        write_byte(8'ha5, a2);
        write_byte(8'h5a, a3);
        i2c_stop();
        wait_clk(10);
        chk("wr_acks", {a0, a1, a2, a3}, 4'b0000);
        chk("wr_we_count", we_n, 2);
        chk("wr_we0", {we_addr[0], we_data[0]}, 16'h10a5);
        chk("wr_we1", {we_addr[1], we_data[1]}, 16'h115a);
        chk("wr_reg_addr", reg_addr, 8'h12);
        chk("wr_busy_after", busy, 0);
        chk("wr_addressed_after", addressed, 0);

        // Random-access read: set pointer, repeated START, read two bytes
        i2c_start();
        write_byte(8'h7c, a0);
        write_byte(8'h20, a1);
        i2c_start();
        write_byte(8'h7d, a2);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        i2c_stop();
        wait_clk(10);
        chk("rd_acks", {a0, a1, a2}, 3'b000);
        chk("rd_byte0", d0, 8'h33);
        chk("rd_byte1", d1, 8'h44);
        chk("rd_re_count", re_n, 2);
        chk("rd_no_we", we_n, 2);
        chk("rd_reg_addr", reg_addr, 8'h21);

        // Foreign address: no ACK, no strobes
        i2c_start();
        write_byte(8'h42, a0);
        chk("mm_addressed", addressed, 0);
        chk("mm_busy", busy, 1);
        write_byte(8'h01, a1);
        write_byte(8'h02, a2);
        i2c_stop();
        wait_clk(10);
        chk("mm_nacks", {a0, a1, a2}, 3'b111);
        chk("mm_no_we", we_n, 2);

        // Pointer wraps from 0xff to 0x00
        i2c_start();
        write_byte(8'h7c, a0);
        write_byte(8'hff, a1);
        write_byte(8'hd1, a2);
        write_byte(8'hd2, a3);
        i2c_stop();
        wait_clk(10);
        chk("wrap_acks", {a0, a1, a2, a3}, 4'b0000);
        chk("wrap_we0", {we_addr[2], we_data[2]}, 16'hffd1);
        chk("wrap_we1", {we_addr[3], we_data[3]}, 16'h00d2);
        chk("wrap_reg_addr", reg_addr, 8'h01);

        // Reset while the target drives a 0 data bit
        i2c_start();
        write_byte(8'h7c, a0);
        write_byte(8'h40, a1);
        i2c_start();
        write_byte(8'h7d, a2);
        chk("rr_acks", {a0, a1, a2}, 3'b000);
        host_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        chk("rr_bit7_low", sda, 0);
        res_n = 1'b0;
        #1;
        chk("rr_sda_released", sda, 1);
        chk("rr_busy", busy, 0);
        chk("rr_reg_addr", reg_addr, 8'h00);
        wait_clk(5);
        res_n = 1'b1;
        wait_clk(10);
        i2c_start();
        write_byte(8'h7c, a0);
        write_byte(8'h05, a1);
        write_byte(8'h77, a2);
        i2c_stop();
        wait_clk(10);
        chk("rr_next_acks", {a0, a1, a2}, 3'b000);
        chk("rr_next_we_count", we_n, 5);
        chk("rr_next_we", {we_addr[4], we_data[4]}, 16'h0577);
        chk("rr_next_reg_addr", reg_addr, 8'h06);

        // STOP after four data bits aborts the write
        i2c_start();
        write_byte(8'h7c, a0);
        write_byte(8'h30, a1);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        i2c_stop();
        wait_clk(10);
        chk("ab_acks", {a0, a1}, 2'b00);
        chk("ab_no_we", we_n, 5);
        chk("ab_busy", busy, 0);
        chk("ab_addressed", addressed, 0);
        chk("ab_reg_addr", reg_addr, 8'h30);
        chk("ab_sda_idle", sda, 1);
        chk("we_re_exclusive", both_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) giving an external I2C host read/write access to an 8-bit-addressed, 8-bit-data register space: detector thresholds, debug counters, camera shadow registers.
- Opposite end of the on-chip I2C master used for LCD and camera setup.
- Oversamples the bus on the system clock and presents a single-cycle register strobe interface to the core.
- No clock stretching. 7-bit addressing only. Standard/fast mode only.

Parameters:
- DEV_ADDR, 7'h3e: 7-bit target address matched against the first byte after START.
- SYNC_STAGES, 2: synchronizer depth for the SCL and SDA inputs (≥2).

Ports:
- clk  in  1  system clock; must be ≥16× the SCL frequency.
- res_n  in  1  asynchronous, active-low reset.
- i2c_clk  in  1  SCL from the bus.
- i2c_sda  inout  1  SDA. Open-drain: the block drives 0 or Z, never 1.
- reg_addr  out  8  current register pointer.
- reg_wdata  out  8  write data; valid while reg_we=1.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read request.
- reg_rdata  in  8  read data; must be valid exactly 1 clk after reg_re.
- busy  out  1  high from START to STOP.
- addressed  out  1  high while the current transaction targets DEV_ADDR.

Behaviour:
- Reset (res_n=0, async): SDA released (Z), reg_we=0, reg_re=0, busy=0, addressed=0, reg_addr=8'h00, state IDLE. Reset mid-transfer drops the transaction immediately; the bus is released within 0 clk of assertion.
- Input conditioning: SCL and SDA each pass through SYNC_STAGES flops. Edges are detected on the synchronized values: scl_rise, scl_fall, start (SDA falls while SCL high), stop (SDA rises while SCL high).
- START or repeated START, from any state: bit counter cleared, go to DEV_ADDR, busy=1.
- STOP, from any state: go to IDLE, busy=0, addressed=0, SDA released.
- Bit timing:
  - Sample SDA on scl_rise.
  - Change the driven SDA 1 clk after scl_fall.
  - Bits are MSB first.
- States:
  - IDLE: SDA released.
  - DEV_ADDR: shift 8 bits.
    - If bits[7:1]==DEV_ADDR: addressed=1, go to DEV_ACK. If R/W=1, pulse reg_re on the 8th scl_rise.
    - On mismatch: go to WAIT_STOP, no ACK.
  - DEV_ACK: drive SDA=0 from the scl_fall after bit 8 to the scl_fall after bit 9. Then go to REG_ADDR if R/W=0, or RDATA if R/W=1.
  - REG_ADDR: shift 8 bits. On the 8th scl_rise load reg_addr. Go to REG_ACK (ACK as above), then WDATA.
  - WDATA: shift 8 bits. On the 8th scl_rise, reg_wdata=byte and reg_we pulses 1 clk. reg_addr increments the clk after reg_we, 8-bit wrap 8'hff→8'h00. Then WDATA_ACK (ACK), then WDATA.
  - RDATA:
    - reg_rdata is captured into the shift register 1 clk after reg_re.
    - Bit 7 goes out after the ACK-ending scl_fall; each subsequent bit goes out after each scl_fall.
    - Drive 0 for a 0 bit; release for a 1 bit.
    - After 8 bits, release SDA and go to MACK.
  - MACK: sample SDA on the 9th scl_rise.
    - 0 (ACK): reg_addr+1 (wrap), pulse reg_re, return to RDATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; wait for STOP or START.
- reg_addr persists across transactions. A write of only the register byte followed by repeated START + read yields a random-access read.
- reg_we and reg_re are never asserted in the same cycle.
- Arbitration and general call (address 0) are not supported; address 0 is treated as a mismatch.

Decomposition:
- Shared package i2c_pkg: state enum, and the ACK/NACK and R/W bit constants, shared with the master.
- One natural sub-module: i2c_bus_sync (synchronizers plus start/stop/edge detection), reusable by a future bus monitor.

Test Plan:
- Write (100 kHz, clk 25 MHz): START, 0x7c, 0x10, 0xa5, 0x5a, STOP → ACK on all bytes; reg_we pulses with (0x10,0xa5) then (0x11,0x5a); reg_addr=0x12 after.
- Random read: START, 0x7c, 0x20, rSTART, 0x7d, host ACK, host NACK, STOP → model returns 0x33 at 0x20 and 0x44 at 0x21; host receives 0x33, 0x44; exactly 2 reg_re pulses.
- Address mismatch: START, 0x42, 0x01, 0x02, STOP → no ACK (SDA high on bit 9); no reg_we; addressed=0.
- Wrap: write at reg 0xff with 2 data bytes → reg_we at 0xff then 0x00.
- Reset mid-read: res_n=0 while driving a 0 data bit → SDA released in the same cycle, busy=0, reg_addr=0x00; next transaction completes normally.
- STOP inside a byte after 4 bits of WDATA → no reg_we, state IDLE, busy=0.
